tile_read_arbiter: RTL and testbench

TILE_READ_ARBITER -- requirements
Module: tile_read_arbiter

---
 rtl/tile_read_arbiter.sv | 135 +++++++++++++
 tb/tb_tile_read_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_read_arbiter.sv
// rtl/tile_read_arbiter.sv - round-robin map tile read arbiter; TILE_ARB_PLAYER_PRIO_EN gives requester 0 strict priority
module tile_read_arbiter #(
    parameter int          NREQ     = 4,
    parameter int          RD_LAT   = 2,
    parameter int          MAP_W    = 13,
    parameter int          MAP_H    = 13,
    parameter logic [15:0] OOB_TILE = 16'hFFFF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   req_x,
    input  logic [4*NREQ-1:0]   req_y,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     rvalid,
    output logic [15:0]         rdata,
    output logic                busy,
    output logic                ram_en,
    output logic [7:0]          ram_addr,
    input  logic [15:0]         ram_dout
);

    localparam int          PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [31:0] MAP_W_U   = 32'(MAP_W);
    localparam logic [31:0] MAP_H_U   = 32'(MAP_H);
    localparam logic [2:0]  WAIT_INIT = 3'(RD_LAT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic [2:0]    wcnt;
    logic [3:0]    lat_x;
    logic [3:0]    lat_y;

    logic          sel_found;
    logic [PW-1:0] sel_idx;
    logic [PW-1:0] cand;
    logic [3:0]    sel_x;
    logic [3:0]    sel_y;
    logic          in_map;
    logic [7:0]    lat_addr;

    // Scan from ptr; with player priority requester 0 overrides the scan result
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = PW'((int'(ptr) + i) % NREQ);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
`ifdef TILE_ARB_PLAYER_PRIO_EN
        if (req[0]) begin
            sel_found = 1'b1;
            sel_idx   = '0;
        end
`endif
    end

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_idx == PW'(i)) begin
                sel_x = req_x[4*i +: 4];
                sel_y = req_y[4*i +: 4];
            end
        end
    end

    assign in_map   = ({28'd0, lat_x} < MAP_W_U) && ({28'd0, lat_y} < MAP_H_U);
    assign lat_addr = 8'({28'd0, lat_y} * MAP_W_U + {28'd0, lat_x});

    assign busy     = (state != IDLE);
    assign ram_en   = (state == ISSUE) && in_map;
    assign ram_addr = (state == ISSUE) ? lat_addr : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            rvalid <= '0;
            rdata  <= '0;
            ptr    <= '0;
            wcnt   <= '0;
            lat_x  <= '0;
            lat_y  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
                        lat_x <= sel_x;
                        lat_y <= sel_y;
`ifdef TILE_ARB_PLAYER_PRIO_EN
                        if (sel_idx != '0)
                            ptr <= (sel_idx == PW'(NREQ-1)) ? '0 : sel_idx + 1'b1;
`else
                        ptr <= (sel_idx == PW'(NREQ-1)) ? '0 : sel_idx + 1'b1;
`endif
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    wcnt  <= WAIT_INIT;
                    state <= WAIT;
                end
                // Final WAIT cycle is the one in which ram_dout is valid
                WAIT: begin
                    if (wcnt == 3'd0) begin
                        rdata  <= in_map ? ram_dout : OOB_TILE;
                        rvalid <= gnt;
                        state  <= RESP;
                    end else begin
                        wcnt <= wcnt - 3'd1;
                    end
                end
                RESP: begin
                    gnt    <= '0;
                    rvalid <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_read_arbiter.sv
// tb/tb_tile_read_arbiter.sv - self-checking bench for tile_read_arbiter with transaction-timeline model
module tb_tile_read_arbiter;

    localparam int          NREQ   = 4;
    localparam int          RD_LAT = 2;
    localparam int          MAP_W  = 13;
    localparam int          MAP_H  = 13;
    localparam logic [15:0] OOB    = 16'hFFFF;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] req_x;
    logic [4*NREQ-1:0] req_y;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rvalid;
    logic [15:0]       rdata;
    logic              busy;
    logic              ram_en;
    logic [7:0]        ram_addr;
    logic [15:0]       ram_dout;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    tile_read_arbiter #(
        .NREQ(NREQ), .RD_LAT(RD_LAT), .MAP_W(MAP_W), .MAP_H(MAP_H), .OOB_TILE(OOB)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x), .req_y(req_y),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout)
    );

    function automatic logic [15:0] mem_f(input logic [7:0] a);
        return 16'(a) * 16'd3 + 16'h0100;
    endfunction

    // Map RAM: data for an enabled address appears RD_LAT cycles after the enable cycle
    logic       pv [0:6];
    logic [7:0] pa [0:6];
    always @(posedge clk) begin
        pv[0] <= ram_en;
        pa[0] <= ram_addr;
        for (int k = 1; k < 7; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
        end
    end
    assign ram_dout = pv[RD_LAT-1] ? mem_f(pa[RD_LAT-1]) : 16'hDEAD;

    // Model: mk is the cycle number within the current transaction (0 = none active)
    int          mk = 0;
    int          mw = 0;
    int          mptr = 0;
    int          mx = 0;
    int          my = 0;
    logic [15:0] mrdata = 16'h0;

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
`ifdef TILE_ARB_PLAYER_PRIO_EN
        if (r[0]) return 0;
`endif
        for (int i = 0; i < NREQ; i++)
            if (r[(p + i) % NREQ]) return (p + i) % NREQ;
        return 0;
    endfunction

    function automatic int next_ptr(input int w, input int p);
`ifdef TILE_ARB_PLAYER_PRIO_EN
        if (w == 0) return p;
`endif
        return (w + 1) % NREQ;
    endfunction

    function automatic int slice_of(input logic [4*NREQ-1:0] v, input int idx);
        return int'((v >> (4 * idx)) & 16'hF);
    endfunction

    function automatic logic m_inmap();
        return (mx < MAP_W) && (my < MAP_H);
    endfunction

    function automatic logic [7:0] m_addr();
        return 8'((my * MAP_W + mx) % 256);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mk     <= 0;
            mw     <= 0;
            mptr   <= 0;
            mrdata <= 16'h0;
        end else if (mk == 0) begin
            if (req != '0) begin
                mw   <= pick(req, mptr);
                mptr <= next_ptr(pick(req, mptr), mptr);
                mx   <= slice_of(req_x, pick(req, mptr));
                my   <= slice_of(req_y, pick(req, mptr));
                mk   <= 1;
            end
        end else if (mk == RD_LAT + 2) begin
            mk <= 0;
        end else begin
            if (mk == RD_LAT + 1)
                mrdata <= m_inmap() ? mem_f(m_addr()) : OOB;
            mk <= mk + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_gnt", 32'(gnt), (mk != 0) ? (32'd1 << mw) : 32'd0);
            chk("m_busy", 32'(busy), 32'(mk != 0));
            chk("m_rvalid", 32'(rvalid), (mk == RD_LAT + 2) ? (32'd1 << mw) : 32'd0);
            chk("m_ram_en", 32'(ram_en), 32'((mk == 1) && m_inmap()));
            if (mk == 1 && m_inmap())
                chk("m_ram_addr", 32'(ram_addr), 32'(m_addr()));
            chk("m_rdata", 32'(rdata), 32'(mrdata));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_xy(input int i, input logic [3:0] x, input logic [3:0] y);
        req_x[4*i +: 4] = x;
        req_y[4*i +: 4] = y;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step(2);
        rst = 1'b0;
    endtask

    logic [3:0] vx [0:3];
    logic [3:0] vy [0:3];

    initial begin
        rst = 1'b1; req = '0; req_x = '0; req_y = '0;
        step(3);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ram_en", 32'(ram_en), 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Single request at (6,11)
        set_xy(0, 4'd6, 4'd11); req = 4'b0001;
        step(1);
        chk("t1_gnt_c1", 32'(gnt), 32'h1);
        chk("t1_ram_en_c1", 32'(ram_en), 32'h1);
        chk("t1_ram_addr_c1", 32'(ram_addr), 32'd149);
        step(2);
        chk("t1_gnt_c3", 32'(gnt), 32'h1);
        step(1);
        chk("t1_rvalid_c4", 32'(rvalid), 32'h1);
        chk("t1_rdata_c4", 32'(rdata), 32'h02BF);
        req = '0;
        step(1);
        chk("t1_busy_c5", 32'(busy), 32'h0);

        // Round-robin with all requesters held
        do_reset();
        for (int i = 0; i < NREQ; i++) set_xy(i, 4'(i + 1), 4'(2 * i));
        req = 4'b1111;
        step(1);  chk("rr_g0", 32'(gnt), 32'b0001);
        step(5);  chk("rr_g1", 32'(gnt), 32'b0010);
        step(5);  chk("rr_g2", 32'(gnt), 32'b0100);
        step(5);  chk("rr_g3", 32'(gnt), 32'b1000);
        step(5);  chk("rr_g4", 32'(gnt), 32'b0001);
        req = '0;
        step(5);

        // Off-map x
        set_xy(2, 4'd13, 4'd2); req = 4'b0100;
        step(1);  chk("oob_ram_en_c1", 32'(ram_en), 32'h0);
        step(3);
        chk("oob_rvalid_c4", 32'(rvalid), 32'b0100);
        chk("oob_rdata_c4", 32'(rdata), 32'hFFFF);
        req = '0;
        step(2);

        // Map-edge vectors checked through the model
        vx[0] = 4'd12; vy[0] = 4'd12;
        vx[1] = 4'd0;  vy[1] = 4'd13;
        vx[2] = 4'd15; vy[2] = 4'd15;
        vx[3] = 4'd0;  vy[3] = 4'd0;
        for (int v = 0; v < 4; v++) begin
            set_xy(3, vx[v], vy[v]); req = 4'b1000;
            step(4);
            req = '0;
            step(2);
        end

        // Reset during WAIT
        set_xy(0, 4'd3, 4'd3); req = 4'b0001;
        step(2);
        rst = 1'b1; req = '0;
        step(1);
        chk("rw_busy_c3", 32'(busy), 32'h0);
        chk("rw_gnt_c3", 32'(gnt), 32'h0);
        chk("rw_rvalid_c3", 32'(rvalid), 32'h0);
        rst = 1'b0;
        set_xy(2, 4'd6, 4'd11); req = 4'b0100;
        step(1);
        chk("rw_gnt_c4", 32'(gnt), 32'b0100);
        chk("rw_ram_addr_c4", 32'(ram_addr), 32'd149);
        step(3);
        chk("rw_rvalid_c7", 32'(rvalid), 32'b0100);
        chk("rw_rdata_c7", 32'(rdata), 32'h02BF);
        req = '0;
        step(2);

        // Requester 1 abandons its request mid-transaction
        do_reset();
        set_xy(1, 4'd2, 4'd5); set_xy(3, 4'd7, 4'd1);
        req = 4'b0010;
        step(1);  chk("ab_gnt_c1", 32'(gnt), 32'b0010);
        step(1);  req = 4'b1000;
        step(2);  chk("ab_rvalid_c4", 32'(rvalid), 32'b0010);
        step(2);  chk("ab_gnt_c6", 32'(gnt), 32'b1000);
        req = '0;
        step(5);

        // Coordinates changing after grant must not affect the access
        set_xy(0, 4'd1, 4'd1); req = 4'b0001;
        step(1);
        chk("xy_ram_addr_c1", 32'(ram_addr), 32'd14);
        set_xy(0, 4'd9, 4'd9);
        step(3);
        chk("xy_rdata_c4", 32'(rdata), 32'h012A);
        req = '0;
        step(2);

`ifdef TILE_ARB_PLAYER_PRIO_EN
        do_reset();
        for (int i = 0; i < NREQ; i++) set_xy(i, 4'(i), 4'(i));
        req = 4'b1111;
        step(1);  chk("pr_g0", 32'(gnt), 32'b0001);
        step(5);  chk("pr_g1", 32'(gnt), 32'b0001);
        step(5);  chk("pr_g2", 32'(gnt), 32'b0001);
        req = 4'b1110;
        step(5);  chk("pr_g3", 32'(gnt), 32'b0010);
        step(5);  chk("pr_g4", 32'(gnt), 32'b0100);
        step(5);  chk("pr_g5", 32'(gnt), 32'b1000);
        req = '0;
        step(5);
`endif

        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
